button_conditioner: RTL and testbench

//  Cleans raw push-button/switch inputs before they reach the turn-signal FSM and clock divider.
//  Per channel: 2-FF synchroniser, counter-based debounce filter, and single-cycle edge pulses.

---
 rtl/button_conditioner_if.sv | 31 +++
 rtl/button_conditioner.sv | 143 ++++++++++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and their conditioned level/pulse outputs.
// The btn_fall signal exists only when FALL_PULSE_EN is defined.
interface button_conditioner_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_rise;
`ifdef FALL_PULSE_EN
  logic [N_CH-1:0] btn_fall;
`endif

  // The conditioner drives the cleaned signals; the consumer drives the raw inputs.
  modport master (
    input  btn_raw,
`ifdef FALL_PULSE_EN
    output btn_fall,
`endif
    output btn_level,
    output btn_rise
  );

  modport slave (
    output btn_raw,
`ifdef FALL_PULSE_EN
    input  btn_fall,
`endif
    input  btn_level,
    input  btn_rise
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchroniser, counter debounce and registered edge pulses.
// Optional feature macro: FALL_PULSE_EN adds the btn_fall pulse output.
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic                    clk,
  input  logic                    rst,
  button_conditioner_if.master    bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Acceptance happens on the edge that observes the last of DEBOUNCE_CYCLES stable samples.
  localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
  localparam bit               ACCEPT_ON_ENTRY = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_0 = 2'd0,
    PEND_1   = 2'd1,
    STABLE_1 = 2'd2,
    PEND_0   = 2'd3
  } deb_state_e;

  logic [N_CH-1:0] sync_s1;
  logic [N_CH-1:0] sync_s2;
  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] rise_vec;
`ifdef FALL_PULSE_EN
  logic [N_CH-1:0] fall_vec;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= bus.btn_raw;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
`ifdef FALL_PULSE_EN
    logic             fall_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= STABLE_0;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
`ifdef FALL_PULSE_EN
        fall_q  <= 1'b0;
`endif
      end else begin
        rise_q <= 1'b0;
`ifdef FALL_PULSE_EN
        fall_q <= 1'b0;
`endif
        case (state)
          STABLE_0: begin
            if (sync_s2[ch]) begin
              if (ACCEPT_ON_ENTRY) begin
                state   <= STABLE_1;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state <= PEND_1;
                cnt   <= CNT_ONE;
              end
            end
          end
          PEND_1: begin
            if (!sync_s2[ch]) begin
              state <= STABLE_0;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= STABLE_1;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STABLE_1: begin
            if (!sync_s2[ch]) begin
              if (ACCEPT_ON_ENTRY) begin
                state   <= STABLE_0;
                level_q <= 1'b0;
`ifdef FALL_PULSE_EN
                fall_q  <= 1'b1;
`endif
              end else begin
                state <= PEND_0;
                cnt   <= CNT_ONE;
              end
            end
          end
          PEND_0: begin
            if (sync_s2[ch]) begin
              state <= STABLE_1;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= STABLE_0;
              level_q <= 1'b0;
`ifdef FALL_PULSE_EN
              fall_q  <= 1'b1;
`endif
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE_0;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level_vec[ch] = level_q;
    assign rise_vec[ch]  = rise_q;
`ifdef FALL_PULSE_EN
    assign fall_vec[ch]  = fall_q;
`endif
  end

  assign bus.btn_level = level_vec;
  assign bus.btn_rise  = rise_vec;
`ifdef FALL_PULSE_EN
  assign bus.btn_fall  = fall_vec;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: hand sequences, a vector table and a random run
// against a sliding-window reference model (N_CH=4, DEBOUNCE_CYCLES=4).
module tb_button_conditioner;
  localparam int N_CH = 4;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  button_conditioner_if #(.N_CH(N_CH)) btn_if ();
  button_conditioner #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (btn_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last DEB samples seen after the
  // synchroniser all disagree with it.
  logic [N_CH-1:0] m_pipe [2];
  logic [N_CH-1:0] m_hist [DEB];
  logic [N_CH-1:0] m_obs, m_level, m_rise, m_fall;
  bit              m_all;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
    end else begin
      m_obs     = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = btn_if.btn_raw;
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_obs;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_all = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_hist[k][c] == m_level[c]) m_all = 1'b0;
        if (m_all) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_rise[c] = 1'b1;
          else            m_fall[c] = 1'b1;
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_if.btn_raw = '0;
    edge1();
    edge1();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N_CH-1:0] raw;
    int              hold;
    logic [N_CH-1:0] exp_level;
    logic [N_CH-1:0] exp_rise;
    logic [N_CH-1:0] exp_fall;
  } vec_t;

  vec_t            vecs [8];
  logic [N_CH-1:0] acc_rise, acc_fall, fall_obs, exp_v;
  bit              pat [6];
  int              rst_hold;

`ifdef FALL_PULSE_EN
  assign fall_obs = btn_if.btn_fall;
`else
  assign fall_obs = '0;
`endif

  initial begin
    vecs[0] = '{4'b0001, 6, 4'b0001, 4'b0001, 4'b0000};
    vecs[1] = '{4'b0011, 5, 4'b0001, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0011, 1, 4'b0011, 4'b0010, 4'b0000};
    vecs[3] = '{4'b0010, 6, 4'b0010, 4'b0000, 4'b0001};
    vecs[4] = '{4'b1100, 6, 4'b1100, 4'b1100, 4'b0010};
    vecs[5] = '{4'b0000, 3, 4'b1100, 4'b0000, 4'b0000};
    vecs[6] = '{4'b1100, 6, 4'b1100, 4'b0000, 4'b0000};
    vecs[7] = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b1100};

    // Reset held with all inputs high, then re-debounce after release
    rst = 1'b1;
    btn_if.btn_raw = 4'hF;
    repeat (3) begin
      edge1();
      check("rst_level", btn_if.btn_level, 4'h0);
      check("rst_rise", btn_if.btn_rise, 4'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      edge1();
      check($sformatf("rel_level_e%0d", e), btn_if.btn_level, (e >= 6) ? 4'hF : 4'h0);
      check($sformatf("rel_rise_e%0d", e), btn_if.btn_rise, (e == 6) ? 4'hF : 4'h0);
    end

    // Vector table from a clean reset
    do_reset();
    foreach (vecs[i]) begin
      btn_if.btn_raw = vecs[i].raw;
      acc_rise = '0;
      acc_fall = '0;
      for (int e = 0; e < vecs[i].hold; e++) begin
        edge1();
        acc_rise |= btn_if.btn_rise;
        acc_fall |= fall_obs;
        check("no_rise_and_fall", btn_if.btn_rise & fall_obs, '0);
      end
      check($sformatf("vec%0d_level", i), btn_if.btn_level, vecs[i].exp_level);
      check($sformatf("vec%0d_rise", i), acc_rise, vecs[i].exp_rise);
`ifdef FALL_PULSE_EN
      check($sformatf("vec%0d_fall", i), acc_fall, vecs[i].exp_fall);
`endif
    end

    // Bouncing channel 1: no pulse until six edges after the final 1
    do_reset();
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (pat[j]) begin
      btn_if.btn_raw = {2'b00, pat[j], 1'b0};
      edge1();
      check("bounce_rise", btn_if.btn_rise, 4'h0);
    end
    for (int e = 2; e <= 7; e++) begin
      edge1();
      check($sformatf("bounce_settle_e%0d", e), btn_if.btn_rise, (e == 6) ? 4'b0010 : 4'b0000);
    end

    // Simultaneous press, then reset mid-count
    do_reset();
    btn_if.btn_raw = 4'b1100;
    for (int e = 1; e <= 6; e++) begin
      edge1();
      check($sformatf("dual_rise_e%0d", e), btn_if.btn_rise, (e == 6) ? 4'b1100 : 4'b0000);
    end
    btn_if.btn_raw = 4'b1101;
    repeat (5) begin
      edge1();
      check("pend_no_rise", btn_if.btn_rise, 4'h0);
    end
    check("pre_rst_level", btn_if.btn_level, 4'b1100);
    rst = 1'b1;
    #1;
    check("async_rst_level", btn_if.btn_level, 4'h0);
    edge1();
    edge1();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      edge1();
      check($sformatf("redeb_rise_e%0d", e), btn_if.btn_rise, (e == 6) ? 4'b1101 : 4'b0000);
    end
    check("redeb_level", btn_if.btn_level, 4'b1101);

    // One-sample glitch just before acceptance restarts the count
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      btn_if.btn_raw = (e == 4) ? 4'b0000 : 4'b0001;
      edge1();
      check($sformatf("glitch_rise_e%0d", e), btn_if.btn_rise, (e == 10) ? 4'b0001 : 4'b0000);
    end

    // Randomised bouncy inputs and occasional resets against the model
    do_reset();
    rst_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("rand_level", btn_if.btn_level, m_level);
      check("rand_rise", btn_if.btn_rise, m_rise);
`ifdef FALL_PULSE_EN
      check("rand_fall", fall_obs, m_fall);
`endif
      exp_v = btn_if.btn_raw;
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 9) == 0) exp_v[c] = ~exp_v[c];
      btn_if.btn_raw = exp_v;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        rst_hold = 2;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
